// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the fetch/data memory arbiter.
//   arb_state_e : transaction FSM states (IDLE, REQ, RESP)
//   arb_owner_e : which requester owns the outstanding transaction
`timescale 1ns/1ps
package mem_arb_pkg;

    localparam int unsigned BE_W     = 4;
    localparam int unsigned STREAK_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_e;

    // Saturating increment of the data-grant streak counter
    function automatic logic [STREAK_W-1:0] streak_inc(input logic [STREAK_W-1:0] cur,
                                                       input logic [STREAK_W-1:0] max);
        return (cur < max) ? STREAK_W'(cur + STREAK_W'(1)) : max;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates an instruction-fetch port and a load/store port onto a
// single memory port, one transaction outstanding at a time.
//   clk, rst                 : clock, asynchronous active-high reset
//   if_req/if_addr           : fetch request in; if_gnt/if_rvalid/if_rdata out
//   d_req/d_we/d_addr/d_wdata/d_be : data request in; d_gnt/d_rvalid/d_rdata out
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be : shared memory request out
//   mem_ready/mem_rvalid/mem_rdata           : shared memory handshake/response in
//   busy                     : a transaction is outstanding
`timescale 1ns/1ps
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [DATA_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [BE_W-1:0]       d_be,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [BE_W-1:0]       mem_be,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    arb_state_e            state_q,     state_d;
    arb_owner_e            owner_q,     owner_d;
    logic [STREAK_W-1:0]   streak_q,    streak_d;
    logic                  mem_req_q,   mem_req_d;
    logic                  mem_we_q,    mem_we_d;
    logic [DATA_WIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]       mem_be_q,    mem_be_d;
    logic                  if_rvalid_q, if_rvalid_d;
    logic [DATA_WIDTH-1:0] if_rdata_q,  if_rdata_d;
    logic                  d_rvalid_q,  d_rvalid_d;
    logic [DATA_WIDTH-1:0] d_rdata_q,   d_rdata_d;

    logic gnt_if_c;
    logic gnt_d_c;
    logic done_c;

    // Grant decode: data wins unless a waiting fetch has seen a full data streak.
    // Gated by rst so the grants also read zero while reset is held.
    always_comb begin
        gnt_if_c = 1'b0;
        gnt_d_c  = 1'b0;
        if (!rst && state_q == IDLE) begin
            gnt_if_c = if_req && (!d_req || streak_q == STREAK_MAX);
            gnt_d_c  = d_req && !gnt_if_c;
        end
    end

    // Completion: response together with acceptance in REQ, or first response in RESP
    always_comb begin
        done_c = 1'b0;
        if (state_q == REQ) begin
            done_c = mem_ready && mem_rvalid;
        end else if (state_q == RESP) begin
            done_c = mem_rvalid;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rvalid_d  = 1'b0;
        d_rdata_d   = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (gnt_if_c) begin
                    state_d     = REQ;
                    owner_d     = OWN_IF;
                    streak_d    = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    mem_be_d    = BE_W'(4'hF);
                end else if (gnt_d_c) begin
                    state_d     = REQ;
                    owner_d     = OWN_D;
                    streak_d    = if_req ? streak_inc(streak_q, STREAK_MAX) : '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_be_d    = d_be;
                end else if (!if_req) begin
                    streak_d = '0;
                end
            end
            REQ: begin
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    state_d   = mem_rvalid ? IDLE : RESP;
                end
            end
            RESP: begin
                if (mem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        // Route response to the owner; stores keep the previous load data
        if (done_c) begin
            if (owner_q == OWN_IF) begin
                if_rvalid_d = 1'b1;
                if_rdata_d  = mem_rdata;
            end else begin
                d_rvalid_d = 1'b1;
                if (!mem_we_q) begin
                    d_rdata_d = mem_rdata;
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rvalid_q  <= d_rvalid_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign if_gnt    = gnt_if_c;
    assign d_gnt     = gnt_d_c;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [DW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [DW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [3:0]    d_be;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_be;
    logic          mem_ready;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_WIDTH(DW), .MAX_D_STREAK(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        // inputs
        logic          ir;  logic [DW-1:0] ia;
        logic          dr;  logic dw; logic [DW-1:0] da; logic [DW-1:0] dwd; logic [3:0] dbe;
        logic          rdy; logic rv; logic [DW-1:0] rd;
        // expected outputs
        logic          ig;  logic dg;
        logic          irv; logic [DW-1:0] ird;
        logic          drv; logic [DW-1:0] drd;
        logic          mr;  logic mw; logic [DW-1:0] ma; logic [DW-1:0] mwd; logic [3:0] mbe;
        logic          bsy;
    } vec_t;

    function automatic vec_t mk(
        input logic ir, input logic [DW-1:0] ia,
        input logic dr, input logic dw, input logic [DW-1:0] da, input logic [DW-1:0] dwd,
        input logic [3:0] dbe,
        input logic rdy, input logic rv, input logic [DW-1:0] rd,
        input logic ig, input logic dg, input logic irv, input logic [DW-1:0] ird,
        input logic drv, input logic [DW-1:0] drd,
        input logic mr, input logic mw, input logic [DW-1:0] ma, input logic [DW-1:0] mwd,
        input logic [3:0] mbe, input logic bsy);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd; v.dbe = dbe;
        v.rdy = rdy; v.rv = rv; v.rd = rd;
        v.ig = ig; v.dg = dg; v.irv = irv; v.ird = ird; v.drv = drv; v.drd = drd;
        v.mr = mr; v.mw = mw; v.ma = ma; v.mwd = mwd; v.mbe = mbe; v.bsy = bsy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_if_gnt"},    DW'(if_gnt),    '0);
        chk({tag, "_d_gnt"},     DW'(d_gnt),     '0);
        chk({tag, "_if_rvalid"}, DW'(if_rvalid), '0);
        chk({tag, "_if_rdata"},  if_rdata,       '0);
        chk({tag, "_d_rvalid"},  DW'(d_rvalid),  '0);
        chk({tag, "_d_rdata"},   d_rdata,        '0);
        chk({tag, "_mem_req"},   DW'(mem_req),   '0);
        chk({tag, "_mem_we"},    DW'(mem_we),    '0);
        chk({tag, "_mem_addr"},  mem_addr,       '0);
        chk({tag, "_mem_wdata"}, mem_wdata,      '0);
        chk({tag, "_mem_be"},    DW'(mem_be),    '0);
        chk({tag, "_busy"},      DW'(busy),      '0);
    endtask

    // Holds both requests with an always-ready memory; counts data grants until a fetch grant
    task automatic streak_run(input int run);
        int nd;
        bit got_if;
        nd = 0;
        got_if = 1'b0;
        if_req = 1'b1; if_addr = 32'h300;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h5000; d_wdata = DW'(run); d_be = 4'hF;
        mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0;
        for (int c = 0; c < 40 && !got_if; c++) begin
            #2;
            if (d_gnt) nd++;
            if (if_gnt) got_if = 1'b1;
            tick();
        end
        chk($sformatf("streak%0d_d_gnts", run), DW'(nd), 32'd4);
        chk($sformatf("streak%0d_if_gnt", run), DW'(got_if), 32'd1);
    endtask

    vec_t vecs[16];

    initial begin
        int pulses;

        // in: ir ia  dr dw da dwd dbe  rdy rv rd | exp: ig dg irv ird drv drd  mr mw ma mwd mbe bsy
        vecs[0]  = mk(1, 32'h100, 0,0,0,0,0, 0,0,0,                       1,0, 0,0,            0,0,            0,0,0,0,0, 0);
        vecs[1]  = mk(0, 0,       0,0,0,0,0, 1,1,32'h00500093,            0,0, 0,0,            0,0,            1,0,32'h100,0,4'hF, 1);
        vecs[2]  = mk(0, 0,       0,0,0,0,0, 0,0,0,                       0,0, 1,32'h00500093, 0,0,            0,0,0,0,0, 0);
        vecs[3]  = mk(0, 0,       0,0,0,0,0, 0,0,0,                       0,0, 0,32'h00500093, 0,0,            0,0,0,0,0, 0);
        vecs[4]  = mk(1, 32'h104, 1,0,32'h2000,0,4'hF, 0,0,0,             0,1, 0,32'h00500093, 0,0,            0,0,0,0,0, 0);
        vecs[5]  = mk(1, 32'h104, 0,0,0,0,0, 1,1,32'hDEADBEEF,            0,0, 0,32'h00500093, 0,0,            1,0,32'h2000,0,4'hF, 1);
        vecs[6]  = mk(1, 32'h104, 0,0,0,0,0, 0,0,0,                       1,0, 0,32'h00500093, 1,32'hDEADBEEF, 0,0,0,0,0, 0);
        vecs[7]  = mk(0, 0,       0,0,0,0,0, 1,0,0,                       0,0, 0,32'h00500093, 0,32'hDEADBEEF, 1,0,32'h104,0,4'hF, 1);
        vecs[8]  = mk(0, 0,       0,0,0,0,0, 0,0,0,                       0,0, 0,32'h00500093, 0,32'hDEADBEEF, 0,0,0,0,0, 1);
        vecs[9]  = mk(0, 0,       0,0,0,0,0, 0,1,32'h12345678,            0,0, 0,32'h00500093, 0,32'hDEADBEEF, 0,0,0,0,0, 1);
        vecs[10] = mk(0, 0,       0,0,0,0,0, 0,0,0,                       0,0, 1,32'h12345678, 0,32'hDEADBEEF, 0,0,0,0,0, 0);
        vecs[11] = mk(0, 0,       1,1,32'h3000,32'hCAFEF00D,4'h3, 0,0,0,  0,1, 0,32'h12345678, 0,32'hDEADBEEF, 0,0,0,0,0, 0);
        vecs[12] = mk(0, 0,       0,0,0,0,0, 1,1,32'h55555555,            0,0, 0,32'h12345678, 0,32'hDEADBEEF, 1,1,32'h3000,32'hCAFEF00D,4'h3, 1);
        vecs[13] = mk(0, 0,       0,0,0,0,0, 0,0,0,                       0,0, 0,32'h12345678, 1,32'hDEADBEEF, 0,0,0,0,0, 0);
        vecs[14] = mk(0, 0,       0,0,0,0,0, 0,1,32'h99999999,            0,0, 0,32'h12345678, 0,32'hDEADBEEF, 0,0,0,0,0, 0);
        vecs[15] = mk(0, 0,       0,0,0,0,0, 0,0,0,                       0,0, 0,32'h12345678, 0,32'hDEADBEEF, 0,0,0,0,0, 0);

        rst = 1'b1;
        idle_inputs();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;

        // Per-cycle vectors: fetch, collision, back-to-back, RESP path, store, stray rvalid
        for (int i = 0; i < 16; i++) begin
            if_req = vecs[i].ir; if_addr = vecs[i].ia;
            d_req = vecs[i].dr; d_we = vecs[i].dw; d_addr = vecs[i].da;
            d_wdata = vecs[i].dwd; d_be = vecs[i].dbe;
            mem_ready = vecs[i].rdy; mem_rvalid = vecs[i].rv; mem_rdata = vecs[i].rd;
            #2;
            chk($sformatf("v%0d_if_gnt", i),    DW'(if_gnt),    DW'(vecs[i].ig));
            chk($sformatf("v%0d_d_gnt", i),     DW'(d_gnt),     DW'(vecs[i].dg));
            chk($sformatf("v%0d_if_rvalid", i), DW'(if_rvalid), DW'(vecs[i].irv));
            chk($sformatf("v%0d_if_rdata", i),  if_rdata,       vecs[i].ird);
            chk($sformatf("v%0d_d_rvalid", i),  DW'(d_rvalid),  DW'(vecs[i].drv));
            chk($sformatf("v%0d_d_rdata", i),   d_rdata,        vecs[i].drd);
            chk($sformatf("v%0d_mem_req", i),   DW'(mem_req),   DW'(vecs[i].mr));
            chk($sformatf("v%0d_busy", i),      DW'(busy),      DW'(vecs[i].bsy));
            if (vecs[i].mr) begin
                chk($sformatf("v%0d_mem_we", i),    DW'(mem_we), DW'(vecs[i].mw));
                chk($sformatf("v%0d_mem_addr", i),  mem_addr,    vecs[i].ma);
                chk($sformatf("v%0d_mem_wdata", i), mem_wdata,   vecs[i].mwd);
                chk($sformatf("v%0d_mem_be", i),    DW'(mem_be), DW'(vecs[i].mbe));
            end
            tick();
        end

        // Data streak limit: two rounds prove the streak restarts from zero after a fetch grant
        streak_run(1);
        streak_run(2);
        if_req = 1'b0; d_req = 1'b0;
        tick();
        idle_inputs();
        #2;
        chk("streak_store_keeps_d_rdata", d_rdata, 32'hDEADBEEF);
        tick();

        // Memory stall: ready low for 3 REQ cycles, response 2 cycles after ready
        pulses = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4000; d_be = 4'hF;
        #2;
        chk("stall_d_gnt", DW'(d_gnt), 32'd1);
        tick();
        d_req = 1'b0; d_addr = 32'h0;
        for (int c = 0; c < 3; c++) begin
            #2;
            pulses += int'(d_rvalid);
            chk($sformatf("stall%0d_mem_req", c),  DW'(mem_req), 32'd1);
            chk($sformatf("stall%0d_mem_addr", c), mem_addr,     32'h4000);
            chk($sformatf("stall%0d_mem_we", c),   DW'(mem_we),  32'd0);
            chk($sformatf("stall%0d_mem_be", c),   DW'(mem_be),  32'hF);
            chk($sformatf("stall%0d_busy", c),     DW'(busy),    32'd1);
            tick();
        end
        mem_ready = 1'b1;
        #2;
        pulses += int'(d_rvalid);
        chk("stall_ready_mem_req",  DW'(mem_req), 32'd1);
        chk("stall_ready_mem_addr", mem_addr,     32'h4000);
        tick();
        mem_ready = 1'b0;
        #2;
        pulses += int'(d_rvalid);
        chk("stall_resp_mem_req", DW'(mem_req), 32'd0);
        chk("stall_resp_busy",    DW'(busy),    32'd1);
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'hA5A5A5A5;
        #2;
        pulses += int'(d_rvalid);
        chk("stall_rv_busy", DW'(busy), 32'd1);
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        #2;
        pulses += int'(d_rvalid);
        chk("stall_done_d_rvalid", DW'(d_rvalid), 32'd1);
        chk("stall_done_d_rdata",  d_rdata,       32'hA5A5A5A5);
        chk("stall_done_busy",     DW'(busy),     32'd0);
        tick();
        #2;
        pulses += int'(d_rvalid);
        chk("stall_pulse_count", DW'(pulses), 32'd1);
        tick();

        // Reset while waiting in RESP, then a stale response after release
        if_req = 1'b1; if_addr = 32'h200;
        #2;
        chk("rstresp_if_gnt", DW'(if_gnt), 32'd1);
        tick();
        if_req = 1'b0; if_addr = 32'h0; mem_ready = 1'b1;
        #2;
        chk("rstresp_mem_req", DW'(mem_req), 32'd1);
        tick();
        mem_ready = 1'b0;
        #2;
        chk("rstresp_in_resp_busy", DW'(busy), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk_all_zero("rst_in_resp");
        tick();
        tick();
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
        #2;
        chk("stale_busy", DW'(busy), 32'd0);
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        #2;
        chk_all_zero("after_stale");
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the data/address width.
REQ-002 Parameter MAX_D_STREAK, default 4, SHALL set the maximum consecutive data grants while a fetch waits (range 1..15).
REQ-003 Ports SHALL be:
 clk  input  1  sole clock, rising edge
 rst  input  1  asynchronous, active-high reset
 if_req  input  1  fetch read request, held until if_gnt
 if_addr  input  DATA_WIDTH  fetch byte address
 if_gnt  output  1  fetch request accepted this cycle
 if_rvalid  output  1  one-cycle fetch data-valid pulse
 if_rdata  output  DATA_WIDTH  fetch read data
 d_req  input  1  data request, held until d_gnt
 d_we  input  1  1 = store, 0 = load
 d_addr  input  DATA_WIDTH  data byte address
 d_wdata  input  DATA_WIDTH  store data
 d_be  input  4  store byte enables
 d_gnt  output  1  data request accepted this cycle
 d_rvalid  output  1  one-cycle completion pulse (load data or store ack)
 d_rdata  output  DATA_WIDTH  load data
 mem_req  output  1  shared port request
 mem_we  output  1  shared port write
 mem_addr  output  DATA_WIDTH  shared port address
 mem_wdata  output  DATA_WIDTH  shared port write data
 mem_be  output  4  shared port byte enables
 mem_ready  input  1  memory accepts request this cycle
 mem_rvalid  input  1  memory response valid
 mem_rdata  input  DATA_WIDTH  memory read data
 busy  output  1  transaction outstanding

Function
REQ-004 FSM SHALL have states IDLE, REQ, RESP; one transaction outstanding at a time.
REQ-005 In IDLE, if_gnt/d_gnt SHALL be combinational on the current requests; at most one asserted; zero outside IDLE.
REQ-006 Arbitration: d_req wins unless if_req is high and d_streak == MAX_D_STREAK, in which case if_req wins; if_req alone wins.
REQ-007 On the grant edge, the FSM SHALL register owner and request fields into mem_* (fetch: mem_we=0, mem_be=4'hF, mem_wdata=0) and enter REQ.
REQ-008 In REQ, mem_req SHALL be 1 with mem_* stable until mem_ready is sampled high.
REQ-009 On mem_ready: if mem_rvalid is also high, complete; else enter RESP.
REQ-010 In RESP, mem_req SHALL be 0; the FSM SHALL complete on the first mem_rvalid.
REQ-011 Completion SHALL register mem_rdata into the owner's rdata, pulse the owner's rvalid for exactly one cycle on the next cycle, and return to IDLE.
REQ-012 Stores SHALL also complete via mem_rvalid; d_rdata SHALL hold its previous value on store completion.
REQ-013 Minimum latency: gnt in cycle 0, mem_req in cycle 1, rvalid in cycle 2 when mem_ready=mem_rvalid=1 in cycle 1.
REQ-014 A new grant SHALL be possible in the same cycle an rvalid pulse is asserted (IDLE back-to-back).
REQ-015 d_streak (4-bit) SHALL increment, saturating at MAX_D_STREAK, on each data grant made while if_req is high; it SHALL clear on a fetch grant and when if_req is low in IDLE.
REQ-016 mem_rvalid outside REQ/RESP SHALL be ignored.
REQ-017 busy SHALL be 1 in REQ and RESP.
REQ-018 rdata outputs SHALL hold their values between completions.

Reset
REQ-019 rst SHALL asynchronously force IDLE, d_streak=0, and all outputs to 0, abandoning any outstanding transaction without an rvalid pulse.
REQ-020 A mem_rvalid arriving after reset releases SHALL be ignored per REQ-016.

Structure
REQ-021 A shared package mem_arb_pkg SHALL hold the state enum (IDLE/REQ/RESP) and owner enum (OWN_IF/OWN_D).
REQ-022 The block SHALL be a single module with no sub-modules.

Verification
REQ-023 Fetch only, if_addr=0x100, memory ready+rvalid in 1 cycle, rdata=0x00500093 -> if_gnt cycle 0, mem_req cycle 1, if_rvalid with 0x00500093 cycle 2.
REQ-024 Simultaneous if_req/d_req (load 0x2000) -> d_gnt first; if_gnt on the next IDLE.
REQ-025 Continuous d_req stores with if_req held, MAX_D_STREAK=4 -> exactly 4 d_gnt, then if_gnt, then d_streak=0.
REQ-026 mem_ready held low 3 cycles, then rvalid 2 cycles after ready -> mem_* stable throughout REQ; single d_rvalid pulse; busy high throughout.
REQ-027 rst asserted in RESP, then stale mem_rvalid=1 -> all outputs 0 immediately; no rvalid pulse; FSM in IDLE.
